// File: rtl/sie_sequencer.sv
// Schumann Ignition Event phase sequencer: runs one COHERENCE..DECAY event plus
// a refractory period per accepted trigger and drives the Q14 coupling gain.
module sie_sequencer #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    trigger,
    input  logic                    abort,
    input  logic [15:0]             dur_p2,
    input  logic [15:0]             dur_p3,
    input  logic [15:0]             dur_p4,
    input  logic [15:0]             dur_p5,
    input  logic [15:0]             dur_p6,
    input  logic [15:0]             dur_refr,
    output logic [2:0]              sie_phase,
    output logic                    sie_active,
    output logic                    sie_refractory,
    output logic                    ignition_pulse,
    output logic                    event_done,
    output logic [15:0]             phase_elapsed,
    output logic [15:0]             event_count,
    output logic [7:0]              rejected_count,
    output logic signed [WIDTH-1:0] sie_gain
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd1, S_COH = 3'd2, S_IGN = 3'd3, S_PLAT = 3'd4,
        S_PROP = 3'd5, S_DEC = 3'd6, S_REFR = 3'd7
    } state_t;

    localparam int ONE = 1 << FRAC;

    state_t        state, state_nx;
    logic [15:0]   elapsed_nx;
    logic [5:0][15:0] dur_q;
    logic [15:0]   cur_dur, dur_eff;
    logic          expire, latch, pulse_nx, done_nx, ev_inc, rej_inc;

    function automatic logic signed [WIDTH-1:0] gain_of(input state_t s);
        case (s)
            S_COH, S_DEC:   gain_of = WIDTH'(ONE / 4);
            S_IGN, S_PLAT:  gain_of = WIDTH'(ONE);
            S_PROP:         gain_of = WIDTH'((ONE * 3) / 4);
            default:        gain_of = '0;
        endcase
    endfunction

    always_comb begin
        case (state)
            S_COH:   cur_dur = dur_q[0];
            S_IGN:   cur_dur = dur_q[1];
            S_PLAT:  cur_dur = dur_q[2];
            S_PROP:  cur_dur = dur_q[3];
            S_DEC:   cur_dur = dur_q[4];
            S_REFR:  cur_dur = dur_q[5];
            default: cur_dur = 16'd1;
        endcase
    end

    // A zero duration still occupies one tick.
    assign dur_eff = (cur_dur == 16'd0) ? 16'd1 : cur_dur;
    assign expire  = (phase_elapsed == dur_eff - 16'd1);

    always_comb begin
        state_nx   = state;
        elapsed_nx = phase_elapsed;
        latch      = 1'b0;
        pulse_nx   = 1'b0;
        done_nx    = 1'b0;
        ev_inc     = 1'b0;
        rej_inc    = 1'b0;
        if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state_nx   = S_COH;
                        elapsed_nx = 16'd0;
                        latch      = 1'b1;
                    end
                end
                S_REFR: begin
                    rej_inc = trigger;
                    if (expire) begin
                        state_nx   = S_IDLE;
                        elapsed_nx = 16'd0;
                    end else begin
                        elapsed_nx = phase_elapsed + 16'd1;
                    end
                end
                default: begin
                    rej_inc = trigger;
                    if (abort) begin
                        state_nx   = S_REFR;
                        elapsed_nx = 16'd0;
                        done_nx    = 1'b1;
                        ev_inc     = 1'b1;
                    end else if (expire) begin
                        state_nx   = state_t'(state + 3'd1);
                        elapsed_nx = 16'd0;
                        pulse_nx   = (state == S_COH);
                        done_nx    = (state == S_DEC);
                        ev_inc     = (state == S_DEC);
                    end else begin
                        elapsed_nx = phase_elapsed + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            phase_elapsed  <= 16'd0;
            dur_q          <= '0;
            ignition_pulse <= 1'b0;
            event_done     <= 1'b0;
            event_count    <= 16'd0;
            rejected_count <= 8'd0;
            sie_gain       <= '0;
            sie_active     <= 1'b0;
            sie_refractory <= 1'b0;
        end else begin
            state          <= state_nx;
            phase_elapsed  <= elapsed_nx;
            ignition_pulse <= pulse_nx;
            event_done     <= done_nx;
            sie_gain       <= gain_of(state_nx);
            sie_active     <= (state_nx != S_IDLE) && (state_nx != S_REFR);
            sie_refractory <= (state_nx == S_REFR);
            if (latch)
                dur_q <= {dur_refr, dur_p6, dur_p5, dur_p4, dur_p3, dur_p2};
            if (ev_inc)
                event_count <= event_count + 16'd1;
            if (rej_inc && rejected_count != 8'd255)
                rejected_count <= rejected_count + 8'd1;
        end
    end

    assign sie_phase = state;
endmodule
